// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Two-requester writeback arbiter (EX stage and load unit) that drives a
// single register-file write port one cycle after the grant. It also keeps
// a per-register reservation scoreboard: ID reserves a destination, and a
// writeback to that register clears the reservation.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_v_i,
    input  logic [3:0]        ex_name_i,
    input  logic [DATA_W-1:0] ex_data_i,
    output logic              ex_rdy_o,

    input  logic              ld_v_i,
    input  logic [3:0]        ld_name_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_rdy_o,

    input  logic              rsv_v_i,
    input  logic [3:0]        rsv_name_i,
    input  logic              flush_i,

    output logic              we_o,
    output logic [3:0]        wname_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [NREG-1:0]   reserved_o
);

    // Round-robin memory: which requester won the most recent grant.
    typedef enum logic {
        LAST_EX = 1'b0,
        LAST_LD = 1'b1
    } last_t;

    last_t                r_last;
    last_t                w_last_nxt;

    logic                 w_ex_gnt;
    logic                 w_ld_gnt;
    logic                 w_gnt;
    logic [3:0]           w_gname;
    logic [DATA_W-1:0]    w_gdata;
    logic [NREG-1:0]      w_res_nxt;

    // Arbitration: sole requester wins; on contention the one not granted
    // last wins. Reset and flush suppress every grant.
    always_comb begin
        w_ex_gnt   = 1'b0;
        w_ld_gnt   = 1'b0;
        w_last_nxt = r_last;
        if (!rst && !flush_i) begin
            if (ex_v_i && ld_v_i) begin
                if (r_last == LAST_LD) begin
                    w_ex_gnt = 1'b1;
                end else begin
                    w_ld_gnt = 1'b1;
                end
            end else begin
                w_ex_gnt = ex_v_i;
                w_ld_gnt = ld_v_i;
            end
        end
        if (w_ex_gnt) begin
            w_last_nxt = LAST_EX;
        end else if (w_ld_gnt) begin
            w_last_nxt = LAST_LD;
        end
    end

    // Select the winning requester's destination and data.
    always_comb begin
        w_gnt   = w_ex_gnt | w_ld_gnt;
        w_gname = ex_name_i;
        w_gdata = ex_data_i;
        if (w_ld_gnt) begin
            w_gname = ld_name_i;
            w_gdata = ld_data_i;
        end
    end

    assign ex_rdy_o = w_ex_gnt;
    assign ld_rdy_o = w_ld_gnt;

    // Scoreboard next state: the grant clears its register first, then a
    // reservation sets its register, so a same-register collision keeps the
    // bit set for the newer producer. Flush wipes everything.
    always_comb begin
        w_res_nxt = reserved_o;
        if (flush_i) begin
            w_res_nxt = '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_gnt && (w_gname == 4'(i))) begin
                    w_res_nxt[i] = 1'b0;
                end
                if (rsv_v_i && (rsv_name_i == 4'(i))) begin
                    w_res_nxt[i] = 1'b1;
                end
            end
        end
    end

    // Last-grant register; reset favours EX on the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= LAST_LD;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    // Registered write port; address and data hold when no grant occurred.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_o    <= 1'b0;
            wname_o <= '0;
            wdata_o <= '0;
        end else begin
            we_o <= w_gnt;
            if (w_gnt) begin
                wname_o <= w_gname;
                wdata_o <= w_gdata;
            end
        end
    end

    // Reservation scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            reserved_o <= '0;
        end else begin
            reserved_o <= w_res_nxt;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_v_i;
    logic [3:0]        ex_name_i;
    logic [DATA_W-1:0] ex_data_i;
    logic              ex_rdy_o;
    logic              ld_v_i;
    logic [3:0]        ld_name_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_rdy_o;
    logic              rsv_v_i;
    logic [3:0]        rsv_name_i;
    logic              flush_i;
    logic              we_o;
    logic [3:0]        wname_o;
    logic [DATA_W-1:0] wdata_o;
    logic [NREG-1:0]   reserved_o;

    wb_port_arbiter #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_v_i     (ex_v_i),
        .ex_name_i  (ex_name_i),
        .ex_data_i  (ex_data_i),
        .ex_rdy_o   (ex_rdy_o),
        .ld_v_i     (ld_v_i),
        .ld_name_i  (ld_name_i),
        .ld_data_i  (ld_data_i),
        .ld_rdy_o   (ld_rdy_o),
        .rsv_v_i    (rsv_v_i),
        .rsv_name_i (rsv_name_i),
        .flush_i    (flush_i),
        .we_o       (we_o),
        .wname_o    (wname_o),
        .wdata_o    (wdata_o),
        .reserved_o (reserved_o)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic              m_we     = 1'b0;
    logic [3:0]        m_wname  = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [NREG-1:0]   m_res    = '0;
    logic              m_lastld = 1'b1;
    logic              m_eg;
    logic              m_lg;

    // Values observed during the most recent step
    logic              s_ex_rdy;
    logic              s_ld_rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the grant, advance the model and the
    // clock, then check the registered outputs.
    task automatic step(input logic r, input logic fl,
                        input logic ev, input logic [3:0] en, input logic [DATA_W-1:0] ed,
                        input logic lv, input logic [3:0] ln, input logic [DATA_W-1:0] ldd,
                        input logic rv, input logic [3:0] rn);
        rst = r; flush_i = fl;
        ex_v_i = ev; ex_name_i = en; ex_data_i = ed;
        ld_v_i = lv; ld_name_i = ln; ld_data_i = ldd;
        rsv_v_i = rv; rsv_name_i = rn;
        #1;
        m_eg = 1'b0;
        m_lg = 1'b0;
        if (!r && !fl) begin
            if (ev && lv) begin
                if (m_lastld) m_eg = 1'b1;
                else          m_lg = 1'b1;
            end else begin
                m_eg = ev;
                m_lg = lv;
            end
        end
        s_ex_rdy = ex_rdy_o;
        s_ld_rdy = ld_rdy_o;
        check_eq("ex_rdy", 64'(ex_rdy_o), 64'(m_eg));
        check_eq("ld_rdy", 64'(ld_rdy_o), 64'(m_lg));

        if (r) begin
            m_we = 1'b0; m_wname = '0; m_wdata = '0; m_res = '0; m_lastld = 1'b1;
        end else begin
            m_we = m_eg | m_lg;
            if (m_eg) begin m_wname = en; m_wdata = ed;  m_lastld = 1'b0; end
            if (m_lg) begin m_wname = ln; m_wdata = ldd; m_lastld = 1'b1; end
            if (fl) begin
                m_res = '0;
            end else begin
                if (m_eg) m_res[en] = 1'b0;
                if (m_lg) m_res[ln] = 1'b0;
                if (rv)   m_res[rn] = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        check_eq("we",       64'(we_o),       64'(m_we));
        check_eq("wname",    64'(wname_o),    64'(m_wname));
        check_eq("wdata",    64'(wdata_o),    64'(m_wdata));
        check_eq("reserved", 64'(reserved_o), 64'(m_res));
    endtask

    task automatic idle();
        step(0, 0, 0, 4'd0, '0, 0, 4'd0, '0, 0, 4'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 4'd0, '0, 0, 4'd0, '0, 0, 4'd0);
    endtask

    logic              pe, pl;
    logic [3:0]        pen, pln;
    logic [DATA_W-1:0] ped, pld;

    function automatic logic [3:0] rnd_name();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 7));
    endfunction

    initial begin
        do_reset();
        do_reset();
        check_eq("rst_we",  64'(we_o), 64'd0);
        check_eq("rst_res", 64'(reserved_o), 64'd0);

        // Single EX writeback
        step(0, 0, 1, 4'd3, 16'h00A5, 0, 4'd0, '0, 0, 4'd0);
        check_eq("single_rdy",   64'(s_ex_rdy), 64'd1);
        check_eq("single_we",    64'(we_o),     64'd1);
        check_eq("single_wname", 64'(wname_o),  64'd3);
        check_eq("single_wdata", 64'(wdata_o),  64'h00A5);
        idle();
        check_eq("single_we_off", 64'(we_o),    64'd0);
        check_eq("single_hold",   64'(wdata_o), 64'h00A5);

        // Contention after reset: EX, LD, EX
        do_reset();
        step(0, 0, 1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0);
        check_eq("cont0_ex", 64'(s_ex_rdy), 64'd1);
        check_eq("cont0_nm", 64'(wname_o),  64'd1);
        step(0, 0, 1, 4'd1, 16'h1112, 1, 4'd2, 16'h2222, 0, 4'd0);
        check_eq("cont1_ld", 64'(s_ld_rdy), 64'd1);
        check_eq("cont1_nm", 64'(wname_o),  64'd2);
        step(0, 0, 1, 4'd1, 16'h1112, 1, 4'd2, 16'h2223, 0, 4'd0);
        check_eq("cont2_ex", 64'(s_ex_rdy), 64'd1);
        check_eq("cont2_nm", 64'(wname_o),  64'd1);

        // Scoreboard: reserve 5, load writes 5 two cycles later
        step(0, 0, 0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd5);
        check_eq("sb_set",  64'(reserved_o[5]), 64'd1);
        idle();
        check_eq("sb_hold", 64'(reserved_o[5]), 64'd1);
        step(0, 0, 0, 4'd0, '0, 1, 4'd5, 16'h5555, 0, 4'd0);
        check_eq("sb_clr",  64'(reserved_o[5]), 64'd0);

        // Collision: reserve and grant register 7 together
        step(0, 0, 1, 4'd7, 16'h0777, 0, 4'd0, '0, 1, 4'd7);
        check_eq("coll_res", 64'(reserved_o[7]), 64'd1);
        check_eq("coll_we",  64'(we_o),          64'd1);
        check_eq("coll_nm",  64'(wname_o),       64'd7);

        // Flush with reserved_o = 0x00F0 and EX pending
        do_reset();
        for (int unsigned i = 4; i < 8; i++) step(0, 0, 0, 4'd0, '0, 0, 4'd0, '0, 1, 4'(i));
        check_eq("fl_pre", 64'(reserved_o), 64'h00F0);
        step(1'b0, 1'b1, 1, 4'd9, 16'h0999, 0, 4'd0, '0, 1, 4'd3);
        check_eq("fl_rdy", 64'(s_ex_rdy),   64'd0);
        check_eq("fl_res", 64'(reserved_o), 64'd0);
        check_eq("fl_we",  64'(we_o),       64'd0);
        step(0, 0, 1, 4'd9, 16'h0999, 0, 4'd0, '0, 0, 4'd0);
        check_eq("fl_after", 64'(s_ex_rdy), 64'd1);

        // Reset mid-operation; last grant was EX, reset must re-favour EX
        step(0, 0, 0, 4'd0, '0, 0, 4'd0, '0, 1, 4'd2);
        step(1, 0, 1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 1, 4'd1);
        check_eq("mr_rdy", 64'({s_ex_rdy, s_ld_rdy}), 64'd0);
        check_eq("mr_out", 64'({we_o, wname_o, wdata_o}), 64'd0);
        check_eq("mr_res", 64'(reserved_o), 64'd0);
        step(0, 0, 1, 4'd4, 16'h4444, 1, 4'd6, 16'h6666, 0, 4'd0);
        check_eq("mr_first", 64'(s_ex_rdy), 64'd1);

        // Randomized traffic; requesters hold until granted
        pe = 1'b0; pl = 1'b0;
        pen = '0; pln = '0; ped = '0; pld = '0;
        for (int unsigned c = 0; c < 1500; c++) begin
            if (!pe && $urandom_range(0, 1) == 1) begin
                pe = 1'b1; pen = rnd_name(); ped = DATA_W'($urandom);
            end
            if (!pl && $urandom_range(0, 1) == 1) begin
                pl = 1'b1; pln = rnd_name(); pld = DATA_W'($urandom);
            end
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 15) == 0),
                 pe, pen, ped, pl, pln, pld,
                 1'($urandom_range(0, 2) == 0), rnd_name());
            if (m_eg) pe = 1'b0;
            if (m_lg) pl = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register data width.
REQ-002 SHALL have parameter NREG, default 16, meaning number of architectural registers; register name width is 4 bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port ex_v_i  input  1  EX-stage writeback request valid.
REQ-006 SHALL have port ex_name_i  input  4  EX destination register.
REQ-007 SHALL have port ex_data_i  input  DATA_W  EX writeback data.
REQ-008 SHALL have port ex_rdy_o  output  1  EX request granted this cycle.
REQ-009 SHALL have port ld_v_i  input  1  load-unit writeback request valid.
REQ-010 SHALL have port ld_name_i  input  4  load destination register.
REQ-011 SHALL have port ld_data_i  input  DATA_W  load writeback data.
REQ-012 SHALL have port ld_rdy_o  output  1  load request granted this cycle.
REQ-013 SHALL have port rsv_v_i  input  1  ID-stage request to reserve a destination register.
REQ-014 SHALL have port rsv_name_i  input  4  register to reserve.
REQ-015 SHALL have port flush_i  input  1  pipeline flush.
REQ-016 SHALL have port we_o  output  1  register-file write enable, registered.
REQ-017 SHALL have port wname_o  output  4  register-file write address, registered.
REQ-018 SHALL have port wdata_o  output  DATA_W  register-file write data, registered.
REQ-019 SHALL have port reserved_o  output  NREG  per-register reservation bit vector, registered.

Function
REQ-020 SHALL grant at most one requester per cycle; ex_rdy_o and ld_rdy_o are combinational from valids, last-grant state and flush_i.
REQ-021 SHALL grant the sole valid requester when only one of ex_v_i, ld_v_i is high.
REQ-022 SHALL, when both are valid, grant the requester not granted most recently (round-robin); last-grant state updates only on a grant.
REQ-023 SHALL keep a request that is not granted pending; the requester holds valid, name and data stable until its rdy is high.
REQ-024 SHALL present the granted name/data on wname_o/wdata_o with we_o=1 exactly one cycle after grant; we_o=0 in any cycle following no grant.
REQ-025 SHALL hold wname_o/wdata_o at their previous values when we_o=0.
REQ-026 SHALL set reserved_o[rsv_name_i] on the edge where rsv_v_i=1.
REQ-027 SHALL clear reserved_o[n] on the edge where a grant for register n is taken.
REQ-028 SHALL, on simultaneous reserve and grant of the same register, leave the bit set (new producer wins).
REQ-029 SHALL, on simultaneous grants/reserves of different registers, apply both updates in the same edge.
REQ-030 SHALL, while flush_i=1, deassert both rdy outputs, clear all reserved_o bits, and ignore rsv_v_i; the next-cycle we_o is 0.
REQ-031 SHALL not alter last-grant state during flush.
REQ-032 SHALL accept a grant to register 0 like any other register (no hardwired-zero handling).

Reset
REQ-033 SHALL, with rst=1 at a rising edge, set we_o=0, wname_o=0, wdata_o=0, reserved_o=0, and last-grant state to "ld" so EX wins the first contention.
REQ-034 SHALL force ex_rdy_o=ld_rdy_o=0 combinationally while rst=1, discarding any in-flight grant.
REQ-035 SHALL give rst priority over flush_i, rsv_v_i and all requests.

Verification
REQ-036 Single EX: ex_v_i=1, name 3, data 0x00A5 for one cycle -> ex_rdy_o=1 same cycle; next cycle we_o=1, wname_o=3, wdata_o=0x00A5; following cycle we_o=0.
REQ-037 Contention: after reset, ex and ld both valid (names 1 and 2) for 3 cycles -> grants EX, LD, EX; we_o stream names 1, 2, 1.
REQ-038 Scoreboard: reserve reg 5, then 2 cycles later ld writes reg 5 -> reserved_o[5]=1 for those cycles, 0 after the grant edge.
REQ-039 Collision: rsv_name_i=7 and EX grant to reg 7 in same cycle -> reserved_o[7] stays 1, we_o=1 with wname_o=7 next cycle.
REQ-040 Flush: reserved_o=0x00F0, ex_v_i=1, flush_i=1 one cycle -> ex_rdy_o=0, next cycle reserved_o=0, we_o=0; EX granted the cycle after flush drops.
REQ-041 Reset mid-operation: rst=1 while both requesters valid and reserved_o nonzero -> no rdy, next cycle all outputs 0; after rst drops EX wins first contention.
